// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer on the device side of the
// CPU-to-device bridge. Register map (addr[3:2]):
//   0 CTRL    bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x one-shot), bit3 IM
//   1 PRESET  32-bit reload value
//   2 COUNT   32-bit current count, read-only
//   3 PRESCALE (TIMER_PRESCALE_EN defined) / reserved, reads 0 (undefined)
// Ports:
//   clk    system clock, rising-edge
//   reset  synchronous active-high reset
//   addr   byte address, only [3:2] decoded
//   we     write strobe, pre-qualified by bridge
//   din    write data
//   dout   combinational read data
//   irq    registered interrupt request (sticky flag gated by IM)
// Optional macro: TIMER_PRESCALE_EN adds the PRESCALE register and count prescaler.
module timer_device #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;
  logic        tick;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pscnt_q, pscnt_d;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  // Read mux
  always_comb begin
    dout = '0;
    case (addr[3:2])
      2'd0: dout = {28'd0, ctrl_q};
      2'd1: dout = preset_q;
      2'd2: dout = count_q;
      default: begin
`ifdef TIMER_PRESCALE_EN
        dout = {{(32-PRESCALE_W){1'b0}}, prescale_q};
`else
        dout = '0;
`endif
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    tick       = 1'b1;
`ifdef TIMER_PRESCALE_EN
    prescale_d = prescale_q;
    pscnt_d    = pscnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
        pscnt_d = '0;
`endif
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          tick    = (pscnt_q == prescale_q);
          pscnt_d = tick ? '0 : pscnt_q + PRESCALE_W'(1);
`endif
          if (tick) begin
            if (count_q > 32'd1) begin
              count_d = count_q - 32'd1;
            end else begin
              count_d    = '0;
              irq_flag_d = 1'b1;
              state_d    = S_INT;
            end
          end
        end
      end
      S_INT: begin
        if (ctrl_q[2:1] == 2'b01) irq_flag_d = 1'b0;
        else                      ctrl_d[0]  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes are applied last so they win over FSM updates to CTRL and
    // irq_flag in the same cycle; the state transition itself is unaffected.
    if (we) begin
      case (addr[3:2])
        2'd0: begin
          ctrl_d     = din[3:0];
          irq_flag_d = 1'b0;
        end
        2'd1: preset_d = din;
        2'd3: begin
`ifdef TIMER_PRESCALE_EN
          prescale_d = din[PRESCALE_W-1:0];
`endif
        end
        default: ;
      endcase
    end

    irq_d = irq_flag_d & ctrl_d[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= '0;
      pscnt_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= prescale_d;
      pscnt_q    <= pscnt_d;
`endif
    end
  end

`ifndef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] unused_prescale_w;
  assign unused_prescale_w = '0;
`endif

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_device.sv
module tb_timer_device;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [31:0] v;

  timer_device #(.PRESCALE_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Leaves time at 1 unit after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; din = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] val);
    addr = a;
    #1;
    val = dout;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(32'h7F00 + 32'(i * 4), v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_fail++; $display("FAIL reset_reg%0d got %h want %h", i, v, 32'h0);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    wr(32'h7F08, 32'hDEADBEEF);
    rd(32'h7F08, v);
    n_cmp++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL count_ro got %h want 0", v); end
  endtask

  task automatic test_autoreload();
    do_reset();
    wr(32'h7F04, 32'd5);
    wr(32'h7F00, 32'hB);            // E0
    step(2); rd(32'h7F08, v);        // after E2
    n_cmp++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL ar_count_e2 got %0d want 5", v); end
    step(4); rd(32'h7F08, v);        // after E6
    n_cmp++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL ar_count_e6 got %0d want 1", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq_e6 got %b want 0", irq); end
    step(1);                          // after E7
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ar_irq_e7 got %b want 1", irq); end
    step(1);                          // after E8
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq_e8 got %b want 0", irq); end
    step(6);                          // after E14
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq_e14 got %b want 0", irq); end
    step(1);                          // after E15
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ar_irq_e15 got %b want 1", irq); end
    step(1);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq_e16 got %b want 0", irq); end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(32'h7F04, 32'd3);
    wr(32'h7F00, 32'h9);            // E0
    step(4); rd(32'h7F08, v);        // after E4
    n_cmp++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL os_count_e4 got %0d want 1", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_irq_e4 got %b want 0", irq); end
    step(1);                          // after E5
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL os_irq_e5 got %b want 1", irq); end
    step(1); rd(32'h7F00, v);        // after E6
    n_cmp++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL os_ctrl_e6 got %h want 8", v); end
    step(20); rd(32'h7F08, v);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL os_irq_sticky got %b want 1", irq); end
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL os_count_end got %0d want 0", v); end
    wr(32'h7F00, 32'h8);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_masking();
    do_reset();
    wr(32'h7F04, 32'd2);
    wr(32'h7F00, 32'h1);            // E0, expiry at E4
    step(4); rd(32'h7F08, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL mk_count_e4 got %0d want 0", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mk_irq_e4 got %b want 0", irq); end
    step(1); rd(32'h7F00, v);
    n_cmp++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL mk_ctrl_e5 got %h want 0", v); end
    step(3);
    wr(32'h7F00, 32'h8);
    step(2);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mk_irq_after_im got %b want 0", irq); end
  endtask

  task automatic test_collision();
    do_reset();
    wr(32'h7F04, 32'd2);
    wr(32'h7F00, 32'h9);            // E0, expiry at E4
    step(4);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL co_irq_e4 got %b want 1", irq); end
    wr(32'h7F00, 32'h9);            // E5, lands on INT cycle
    rd(32'h7F00, v);
    n_cmp++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL co_ctrl_int got %h want 9", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL co_irq_int got %b want 0", irq); end
    step(2); rd(32'h7F08, v);        // after E7
    n_cmp++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL co_reload got %0d want 2", v); end
    step(1);                          // after E8, COUNT=1
    wr(32'h7F00, 32'hB);            // E9 = expiry edge
    rd(32'h7F08, v);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL co_irq_exp got %b want 0", irq); end
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL co_count_exp got %0d want 0", v); end
    step(3); rd(32'h7F08, v);        // after E12: INT, IDLE, LOAD, COUNT=2
    n_cmp++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL co_restart got %0d want 2", v); end
  endtask

  task automatic test_stop_restart();
    do_reset();
    wr(32'h7F04, 32'd10);
    wr(32'h7F00, 32'h1);            // E0
    step(5); rd(32'h7F08, v);        // after E5
    n_cmp++;
    if (v !== 32'd7) begin n_fail++; $display("FAIL sr_count_e5 got %0d want 7", v); end
    wr(32'h7F00, 32'h0);            // E6: last decrement to 6, then halt
    step(4); rd(32'h7F08, v);
    n_cmp++;
    if (v !== 32'd6) begin n_fail++; $display("FAIL sr_hold got %0d want 6", v); end
    wr(32'h7F04, 32'd4);
    wr(32'h7F00, 32'h1);
    step(1); rd(32'h7F08, v);
    n_cmp++;
    if (v !== 32'd6) begin n_fail++; $display("FAIL sr_pre_load got %0d want 6", v); end
    step(1); rd(32'h7F08, v);
    n_cmp++;
    if (v !== 32'd4) begin n_fail++; $display("FAIL sr_reload got %0d want 4", v); end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    wr(32'h7F04, 32'd7);
    wr(32'h7F00, 32'hB);
    step(4);
    do_reset();
    rd(32'h7F08, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rm_count got %0d want 0", v); end
    rd(32'h7F04, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rm_preset got %0d want 0", v); end
    step(5); rd(32'h7F00, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rm_ctrl got %h want 0", v); end
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    do_reset();
    wr(32'h7F0C, 32'd2);
    rd(32'h7F0C, v);
    n_cmp++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL ps_reg got %0d want 2", v); end
    wr(32'h7F04, 32'd3);
    wr(32'h7F00, 32'h9);            // E0, LOAD completes at E2
    step(4); rd(32'h7F08, v);        // after E4
    n_cmp++;
    if (v !== 32'd3) begin n_fail++; $display("FAIL ps_hold got %0d want 3", v); end
    step(1); rd(32'h7F08, v);        // after E5
    n_cmp++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL ps_step got %0d want 2", v); end
    step(5);                          // after E10
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ps_irq_e10 got %b want 0", irq); end
    step(1);                          // after E11
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ps_irq_e11 got %b want 1", irq); end
  endtask
`else
  task automatic test_reserved();
    do_reset();
    wr(32'h7F0C, 32'hFFFF_FFFF);
    rd(32'h7F0C, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rsv_read got %h want 0", v); end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_autoreload();
    test_oneshot();
    test_masking();
    test_collision();
    test_stop_restart();
    test_reset_midcount();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`else
    test_reserved();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
